// File: rtl/psg_pkg.sv
// Shared definitions for the PSG waveform combiner.
// - Combine mode encodings (2 bits wide).
// - Config word layout {sel[NWAVE-1:0], mode[1:0]} and a helper for its width.
package psg_pkg;

  localparam int unsigned PSG_MODE_W = 2;

  localparam logic [PSG_MODE_W-1:0] PSG_CMB_AND = 2'd0;
  localparam logic [PSG_MODE_W-1:0] PSG_CMB_OR  = 2'd1;
  localparam logic [PSG_MODE_W-1:0] PSG_CMB_XOR = 2'd2;
  localparam logic [PSG_MODE_W-1:0] PSG_CMB_MAX = 2'd3;

  // Width of a packed config word {sel, mode} for a given number of waves.
  function automatic int unsigned psg_cfg_w(int unsigned nwave);
    return nwave + PSG_MODE_W;
  endfunction

endpackage

// File: rtl/psg_wave_combine_core.sv
// Purely combinational waveform combiner for one voice sample.
// Ports:
//   sel_i  - waveform select mask, bit k selects wave k
//   mode_i - combine mode (AND / OR / XOR / MAX)
//   wave_i - NWAVE samples, wave k at [k*WID +: WID]
//   res_o  - combined sample; zero when no wave is selected
// Build option: PSG_WAVE_COMBINER_XOR_EN enables the XOR mode; without it
// mode 2 falls back to AND and no XOR logic is built.
module psg_wave_combine_core
  import psg_pkg::*;
#(
  parameter int unsigned WID   = 12,
  parameter int unsigned NWAVE = 5
) (
  input  logic [NWAVE-1:0]     sel_i,
  input  logic [1:0]           mode_i,
  input  logic [NWAVE*WID-1:0] wave_i,
  output logic [WID-1:0]       res_o
);

  logic [WID-1:0] wave_k;
  logic [WID-1:0] and_acc;
  logic [WID-1:0] or_acc;
  logic [WID-1:0] max_acc;
`ifdef PSG_WAVE_COMBINER_XOR_EN
  logic [WID-1:0] xor_acc;
`endif

  always_comb begin
    wave_k  = '0;
    and_acc = '1;
    or_acc  = '0;
    max_acc = '0;
`ifdef PSG_WAVE_COMBINER_XOR_EN
    xor_acc = '0;
`endif
    for (int k = 0; k < NWAVE; k++) begin
      if (sel_i[k]) begin
        wave_k  = wave_i[k*WID +: WID];
        and_acc = and_acc & wave_k;
        or_acc  = or_acc | wave_k;
        if (wave_k > max_acc) begin
          max_acc = wave_k;
        end
`ifdef PSG_WAVE_COMBINER_XOR_EN
        xor_acc = xor_acc ^ wave_k;
`endif
      end
    end
  end

  always_comb begin
    res_o = '0;
    // An empty select mask mutes the voice; the AND seed would otherwise leak all-ones.
    if (sel_i != '0) begin
      case (mode_i)
        PSG_CMB_OR:  res_o = or_acc;
        PSG_CMB_MAX: res_o = max_acc;
`ifdef PSG_WAVE_COMBINER_XOR_EN
        PSG_CMB_XOR: res_o = xor_acc;
`endif
        default:     res_o = and_acc;
      endcase
    end
  end

endmodule

// File: rtl/psg_wave_combiner.sv
// Time-multiplexed multi-voice waveform combiner with per-channel config and a
// 2-stage valid/ready pipeline.
// Ports:
//   clk_i, rst_i         - clock, asynchronous active-high reset
//   cfg_we_i/ch_i/sel_i/mode_i - config write into the channel's pending slot
//   cfg_pend_o           - per-channel "pending config not yet committed" flags
//   in_vld_i/in_rdy_o    - input handshake; in_ch_i, in_wrap_i, wave_i payload
//   out_vld_o/out_rdy_i  - output handshake; out_ch_o, out_o payload
// Pending config is promoted to active only on an accepted sample with
// in_wrap_i=1, so a voice never changes waveform mid-period.
// Build option: PSG_WAVE_COMBINER_XOR_EN (see psg_wave_combine_core).
module psg_wave_combiner
  import psg_pkg::*;
#(
  parameter int unsigned WID    = 12,
  parameter int unsigned NWAVE  = 5,
  parameter int unsigned NCH    = 8,
  parameter int unsigned CHBITS = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_we_i,
  input  logic [CHBITS-1:0]    cfg_ch_i,
  input  logic [NWAVE-1:0]     cfg_sel_i,
  input  logic [1:0]           cfg_mode_i,
  output logic [NCH-1:0]       cfg_pend_o,
  input  logic                 in_vld_i,
  output logic                 in_rdy_o,
  input  logic [CHBITS-1:0]    in_ch_i,
  input  logic                 in_wrap_i,
  input  logic [NWAVE*WID-1:0] wave_i,
  output logic                 out_vld_o,
  input  logic                 out_rdy_i,
  output logic [CHBITS-1:0]    out_ch_o,
  output logic [WID-1:0]       out_o
);

  localparam int unsigned     CfgW = psg_cfg_w(NWAVE);
  localparam logic [CHBITS:0] NchL = NCH[CHBITS:0];

  // Config store: packed {sel, mode} per channel.
  logic [CfgW-1:0] act_cfg_q  [NCH];
  logic [CfgW-1:0] act_cfg_d  [NCH];
  logic [CfgW-1:0] pnd_cfg_q  [NCH];
  logic [CfgW-1:0] pnd_cfg_d  [NCH];
  logic [NCH-1:0]  pend_q, pend_d;

  // Pipeline registers.
  logic                 s1_vld_q, s1_vld_d;
  logic [NWAVE*WID-1:0] s1_wave_q, s1_wave_d;
  logic [CHBITS-1:0]    s1_ch_q, s1_ch_d;
  logic [CfgW-1:0]      s1_cfg_q, s1_cfg_d;
  logic                 s2_vld_q, s2_vld_d;
  logic [CHBITS-1:0]    s2_ch_q, s2_ch_d;
  logic [WID-1:0]       s2_res_q, s2_res_d;

  logic            s1_adv, s2_adv, in_xfer;
  logic            in_ch_ok, cfg_ch_ok, commit, cfg_wr;
  logic [CfgW-1:0] res_cfg;
  logic [WID-1:0]  core_res;

  assign s2_adv   = !s2_vld_q || out_rdy_i;
  assign s1_adv   = !s1_vld_q || s2_adv;
  assign in_rdy_o = s1_adv;
  assign in_xfer  = in_vld_i && in_rdy_o;

  assign in_ch_ok  = {1'b0, in_ch_i} < NchL;
  assign cfg_ch_ok = {1'b0, cfg_ch_i} < NchL;
  assign commit    = in_xfer && in_wrap_i && in_ch_ok && pend_q[in_ch_i];
  assign cfg_wr    = cfg_we_i && cfg_ch_ok;

  // The committing sample already uses the pending config.
  always_comb begin
    res_cfg = '0;
    if (in_ch_ok) begin
      res_cfg = commit ? pnd_cfg_q[in_ch_i] : act_cfg_q[in_ch_i];
    end
  end

  // Commit is applied before the write so a same-channel write in the commit
  // cycle stays pending while the older pending value goes active.
  always_comb begin
    act_cfg_d = act_cfg_q;
    pnd_cfg_d = pnd_cfg_q;
    pend_d    = pend_q;
    if (commit) begin
      act_cfg_d[in_ch_i] = pnd_cfg_q[in_ch_i];
      pend_d[in_ch_i]    = 1'b0;
    end
    if (cfg_wr) begin
      pnd_cfg_d[cfg_ch_i] = {cfg_sel_i, cfg_mode_i};
      pend_d[cfg_ch_i]    = 1'b1;
    end
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_wave_d = s1_wave_q;
    s1_ch_d   = s1_ch_q;
    s1_cfg_d  = s1_cfg_q;
    if (s1_adv) begin
      s1_vld_d = in_vld_i;
    end
    if (in_xfer) begin
      s1_wave_d = wave_i;
      s1_ch_d   = in_ch_i;
      s1_cfg_d  = res_cfg;
    end
  end

  psg_wave_combine_core #(
    .WID   (WID),
    .NWAVE (NWAVE)
  ) u_core (
    .sel_i  (s1_cfg_q[CfgW-1 -: NWAVE]),
    .mode_i (s1_cfg_q[1:0]),
    .wave_i (s1_wave_q),
    .res_o  (core_res)
  );

  // Output registers only load when a new sample moves in, so they hold under stall.
  always_comb begin
    s2_vld_d = s2_vld_q;
    s2_ch_d  = s2_ch_q;
    s2_res_d = s2_res_q;
    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_ch_d  = s1_ch_q;
        s2_res_d = core_res;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NCH; i++) begin
        act_cfg_q[i] <= '0;
        pnd_cfg_q[i] <= '0;
      end
      pend_q    <= '0;
      s1_vld_q  <= 1'b0;
      s1_wave_q <= '0;
      s1_ch_q   <= '0;
      s1_cfg_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_ch_q   <= '0;
      s2_res_q  <= '0;
    end else begin
      act_cfg_q <= act_cfg_d;
      pnd_cfg_q <= pnd_cfg_d;
      pend_q    <= pend_d;
      s1_vld_q  <= s1_vld_d;
      s1_wave_q <= s1_wave_d;
      s1_ch_q   <= s1_ch_d;
      s1_cfg_q  <= s1_cfg_d;
      s2_vld_q  <= s2_vld_d;
      s2_ch_q   <= s2_ch_d;
      s2_res_q  <= s2_res_d;
    end
  end

  assign cfg_pend_o = pend_q;
  assign out_vld_o  = s2_vld_q;
  assign out_ch_o   = s2_ch_q;
  assign out_o      = s2_res_q;

endmodule

// File: tb/tb_psg_wave_combiner.sv
module tb_psg_wave_combiner;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_ch;
  logic [4:0]  cfg_sel;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_pend;
  logic        in_vld;
  logic        in_rdy;
  logic [2:0]  in_ch;
  logic        in_wrap;
  logic [59:0] wave;
  logic        out_vld;
  logic        out_rdy;
  logic [2:0]  out_ch;
  logic [11:0] out_val;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: active/pending configs per channel.
  logic [4:0] m_act_sel  [8];
  logic [1:0] m_act_mode [8];
  logic [4:0] m_pnd_sel  [8];
  logic [1:0] m_pnd_mode [8];
  bit         m_pend     [8];
  logic [14:0] exp_q[$];
  logic [14:0] obs_q[$];

  psg_wave_combiner dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cfg_we_i   (cfg_we),
    .cfg_ch_i   (cfg_ch),
    .cfg_sel_i  (cfg_sel),
    .cfg_mode_i (cfg_mode),
    .cfg_pend_o (cfg_pend),
    .in_vld_i   (in_vld),
    .in_rdy_o   (in_rdy),
    .in_ch_i    (in_ch),
    .in_wrap_i  (in_wrap),
    .wave_i     (wave),
    .out_vld_o  (out_vld),
    .out_rdy_i  (out_rdy),
    .out_ch_o   (out_ch),
    .out_o      (out_val)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_combine(input logic [4:0] sel, input logic [1:0] mode,
                                              input logic [59:0] w);
    logic [11:0] vals[$];
    logic [11:0] r;
    int m;
    m = int'(mode);
`ifndef PSG_WAVE_COMBINER_XOR_EN
    if (m == 2) m = 0;
`endif
    for (int k = 0; k < 5; k++) if (sel[k]) vals.push_back(w[k*12 +: 12]);
    if (vals.size() == 0) return 12'h000;
    r = (m == 0) ? 12'hFFF : 12'h000;
    foreach (vals[i]) begin
      case (m)
        0: r = r & vals[i];
        1: r = r | vals[i];
        2: r = r ^ vals[i];
        default: if (vals[i] > r) r = vals[i];
      endcase
    end
    return r;
  endfunction

  function automatic logic [59:0] mk_wave(input logic [11:0] a, input logic [11:0] b,
                                          input logic [11:0] c);
    return {24'h0, c, b, a};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_act_sel[i] = '0; m_act_mode[i] = '0;
      m_pnd_sel[i] = '0; m_pnd_mode[i] = '0; m_pend[i] = 0;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // One clock: observe handshakes mid-cycle, advance the model, land #1 after the edge.
  task automatic step(output bit acc);
    int ch;
    logic [4:0] s;
    logic [1:0] m;
    @(negedge clk);
    acc = in_vld && in_rdy;
    if (out_vld && out_rdy) obs_q.push_back({out_ch, out_val});
    if (acc) begin
      ch = int'(in_ch);
      s = m_act_sel[ch];
      m = m_act_mode[ch];
      if (in_wrap && m_pend[ch]) begin
        s = m_pnd_sel[ch];
        m = m_pnd_mode[ch];
        m_act_sel[ch] = s;
        m_act_mode[ch] = m;
        m_pend[ch] = 0;
      end
      exp_q.push_back({in_ch, ref_combine(s, m, wave)});
    end
    if (cfg_we) begin
      m_pnd_sel[cfg_ch] = cfg_sel;
      m_pnd_mode[cfg_ch] = cfg_mode;
      m_pend[cfg_ch] = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input logic [4:0] sel, input logic [1:0] mode);
    bit dummy;
    cfg_we = 1; cfg_ch = 3'(ch); cfg_sel = sel; cfg_mode = mode;
    step(dummy);
    cfg_we = 0;
  endtask

  task automatic send(input int ch, input bit wrap, input logic [59:0] w);
    bit acc;
    acc = 0;
    in_vld = 1; in_ch = 3'(ch); in_wrap = wrap; wave = w;
    for (int i = 0; i < 20 && !acc; i++) step(acc);
    in_vld = 0; in_wrap = 0;
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL send_accept ch%0d: accepted=%0b required=1", ch, acc);
    end
  endtask

  task automatic drain();
    bit dummy;
    out_rdy = 1;
    repeat (4) step(dummy);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_vld, out_ch, out_val, cfg_pend, in_rdy} !== {1'b0, 3'd0, 12'h000, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: vld=%0b ch=%0d out=%h pend=%h rdy=%0b required 0,0,000,00,1",
               out_vld, out_ch, out_val, cfg_pend, in_rdy);
    end
    rst = 0;
    model_clear();
  endtask

  task automatic test_no_config();
    bit acc;
    in_vld = 1; in_ch = 0; in_wrap = 0; wave = mk_wave(12'h0F0, 12'h0FF, 12'h000);
    step(acc);
    in_vld = 0;
    n_checks++;
    if (!acc || out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_1: acc=%0b out_vld=%0b required acc=1 out_vld=0", acc, out_vld);
    end
    step(acc);
    n_checks++;
    if (out_vld !== 1'b1 || out_val !== 12'h000 || out_ch !== 3'd0) begin
      n_fail++;
      $display("FAIL latency_2: vld=%0b out=%h ch=%0d required 1,000,0", out_vld, out_val, out_ch);
    end
    drain();
    n_checks++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL no_config_count: got %0d outputs required 1", obs_q.size());
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_and_commit();
    cfg_write(1, 5'b00011, 2'd0);
    n_checks++;
    if (cfg_pend[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL and_pend_set: pend1=%0b required 1", cfg_pend[1]);
    end
    send(1, 1, mk_wave(12'hF0F, 12'h0FF, 12'h000));
    n_checks++;
    if (cfg_pend[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL and_pend_clear: pend1=%0b required 0", cfg_pend[1]);
    end
    drain();
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {3'd1, 12'h00F}) begin
      n_fail++;
      $display("FAIL and_result: n=%0d got %h required %h", obs_q.size(),
               obs_q.size() ? obs_q[0] : 15'h0, {3'd1, 12'h00F});
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_wrap0_hold();
    cfg_write(2, 5'b00101, 2'd3);
    send(2, 0, mk_wave(12'h123, 12'hFFF, 12'h800));
    n_checks++;
    if (cfg_pend[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap0_pend: pend2=%0b required 1", cfg_pend[2]);
    end
    send(2, 1, mk_wave(12'h123, 12'hFFF, 12'h800));
    drain();
    n_checks++;
    if (obs_q.size() != 2 || obs_q[0] !== {3'd2, 12'h000} || obs_q[1] !== {3'd2, 12'h800}) begin
      n_fail++;
      $display("FAIL max_commit: n=%0d got %h,%h required %h,%h", obs_q.size(),
               obs_q.size() > 0 ? obs_q[0] : 15'h0, obs_q.size() > 1 ? obs_q[1] : 15'h0,
               {3'd2, 12'h000}, {3'd2, 12'h800});
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_mode2();
    logic [11:0] req;
`ifdef PSG_WAVE_COMBINER_XOR_EN
    req = 12'h555;
`else
    req = 12'hAAA;
`endif
    cfg_write(3, 5'b00011, 2'd2);
    send(3, 1, mk_wave(12'hAAA, 12'hFFF, 12'h000));
    drain();
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {3'd3, req}) begin
      n_fail++;
      $display("FAIL mode2_result: got %h required %h", obs_q.size() ? obs_q[0] : 15'h0,
               {3'd3, req});
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_stall();
    bit acc;
    int n_acc;
    logic [14:0] snap;
    n_acc = 0;
    out_rdy = 0;
    in_vld = 1; in_wrap = 0; in_ch = 0;
    wave = {28'($urandom()), 32'($urandom())};
    for (int c = 0; c < 5; c++) begin
      step(acc);
      if (acc) begin
        n_acc++;
        in_ch = 3'(n_acc);
        wave = {28'($urandom()), 32'($urandom())};
      end
      if (c == 1) snap = {out_ch, out_val};
      if (c >= 2) begin
        n_checks++;
        if ({out_vld, out_ch, out_val} !== {1'b1, snap}) begin
          n_fail++;
          $display("FAIL stall_hold c%0d: got %0b/%h required 1/%h", c, out_vld,
                   {out_ch, out_val}, snap);
        end
      end
    end
    n_checks++;
    if (n_acc != 2 || in_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_rdy: accepted=%0d in_rdy=%0b required 2,0", n_acc, in_rdy);
    end
    out_rdy = 1;
    for (int c = 0; c < 20 && n_acc < 4; c++) begin
      step(acc);
      if (acc) begin
        n_acc++;
        in_ch = 3'(n_acc);
        wave = {28'($urandom()), 32'($urandom())};
      end
    end
    in_vld = 0;
    drain();
    n_checks++;
    if (obs_q.size() != 4 || exp_q.size() != 4) begin
      n_fail++;
      $display("FAIL stall_count: got %0d outputs required 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i] || obs_q[i][14:12] !== 3'(i)) begin
          n_fail++;
          $display("FAIL stall_order[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_commit_and_write();
    bit acc;
    cfg_write(4, 5'b00001, 2'd1);
    cfg_we = 1; cfg_ch = 4; cfg_sel = 5'b00010; cfg_mode = 2'd3;
    in_vld = 1; in_ch = 4; in_wrap = 1; wave = mk_wave(12'h321, 12'h654, 12'h000);
    step(acc);
    cfg_we = 0; in_vld = 0; in_wrap = 0;
    n_checks++;
    if (!acc || cfg_pend[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_pend: acc=%0b pend4=%0b required 1,1", acc, cfg_pend[4]);
    end
    send(4, 1, mk_wave(12'h321, 12'h654, 12'h000));
    drain();
    n_checks++;
    if (obs_q.size() != 2 || obs_q[0] !== {3'd4, 12'h321} || obs_q[1] !== {3'd4, 12'h654}
        || cfg_pend[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_result: n=%0d got %h,%h pend4=%0b required %h,%h,0", obs_q.size(),
               obs_q.size() > 0 ? obs_q[0] : 15'h0, obs_q.size() > 1 ? obs_q[1] : 15'h0,
               cfg_pend[4], {3'd4, 12'h321}, {3'd4, 12'h654});
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    bit acc;
    logic [7:0] req_pend;
    for (int c = 0; c < 400; c++) begin
      cfg_we   = ($urandom_range(0, 99) < 20);
      cfg_ch   = 3'($urandom_range(0, 7));
      cfg_sel  = 5'($urandom());
      cfg_mode = 2'($urandom());
      in_vld   = ($urandom_range(0, 99) < 70);
      in_ch    = 3'($urandom_range(0, 7));
      in_wrap  = ($urandom_range(0, 99) < 30);
      wave     = {28'($urandom()), 32'($urandom())};
      out_rdy  = ($urandom_range(0, 99) < 70);
      step(acc);
      for (int i = 0; i < 8; i++) req_pend[i] = m_pend[i];
      if (c % 25 == 0) begin
        n_checks++;
        if (cfg_pend !== req_pend) begin
          n_fail++;
          $display("FAIL rand_pend c%0d: got %h required %h", c, cfg_pend, req_pend);
        end
      end
    end
    cfg_we = 0; in_vld = 0; in_wrap = 0;
    drain();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d outputs required %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand_data[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    bit acc;
    cfg_write(5, 5'b00001, 2'd1);
    in_vld = 1; in_ch = 5; in_wrap = 0; wave = mk_wave(12'h111, 12'h0, 12'h0);
    out_rdy = 0;
    step(acc);
    step(acc);
    in_vld = 0;
    rst = 1;
    #2;
    n_checks++;
    if (out_vld !== 1'b0 || cfg_pend !== 8'h00 || out_val !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid: vld=%0b pend=%h out=%h required 0,00,000", out_vld, cfg_pend,
               out_val);
    end
    @(posedge clk);
    #2;
    rst = 0;
    model_clear();
    drain();
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_discard: got %0d outputs required 0", obs_q.size());
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    cfg_we = 0; cfg_ch = 0; cfg_sel = 0; cfg_mode = 0;
    in_vld = 0; in_ch = 0; in_wrap = 0; wave = '0; out_rdy = 1;
    test_reset();
    test_no_config();
    test_and_commit();
    test_wrap0_hold();
    test_mode2();
    test_stall();
    test_commit_and_write();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/psg_wave_combiner.md
Name: psg_wave_combiner

Overview:
- Time-multiplexed, multi-voice successor to the PSG note-output waveform selector.
- Per voice, it combines any subset of NWAVE waveform samples using a programmable mode: AND (SID-style), OR, MAX, and optionally XOR.
- It sits between the per-voice waveform generators and the envelope/mixer stage.
- It adds per-channel config storage, glitch-free config changes synchronised to phase wrap, and a 2-stage valid/ready pipeline.

Parameters:
- WID, 12, sample width.
- NWAVE, 5, waveforms per voice.
- NCH, 8, voice channels.
- CHBITS, 3, channel index width; must satisfy 2**CHBITS >= NCH.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cfg_we_i  in  1  config write strobe
- cfg_ch_i  in  CHBITS  channel being configured
- cfg_sel_i  in  NWAVE  waveform select mask; bit k selects wave k
- cfg_mode_i  in  2  0=AND, 1=OR, 2=XOR, 3=MAX
- cfg_pend_o  out  NCH  per-channel pending-config flags
- in_vld_i  in  1  input sample valid
- in_rdy_o  out  1  input ready
- in_ch_i  in  CHBITS  channel of the input sample
- in_wrap_i  in  1  phase accumulator wrapped on this sample
- wave_i  in  NWAVE*WID  waveforms; wave k occupies bits [k*WID +: WID]
- out_vld_o  out  1  output valid
- out_rdy_i  in  1  downstream ready
- out_ch_o  out  CHBITS  channel of the output sample
- out_o  out  WID  combined sample

Behaviour:
- Reset (async, rst_i=1): all active and pending configs cleared to sel=0, mode=0; cfg_pend_o=0; pipeline valids=0; out_vld_o=0, out_o=0, out_ch_o=0.
- Config write:
  - When cfg_we_i=1, {sel,mode} is written to pending[cfg_ch_i] and pend[cfg_ch_i] is set.
  - A write with cfg_ch_i >= NCH is ignored.
- Transfers: an input transfer occurs when in_vld_i & in_rdy_o; an output transfer occurs when out_vld_o & out_rdy_i.
- Config commit:
  - On an input transfer with in_wrap_i=1 and pend[in_ch_i]=1, pending is copied to active and pend is cleared.
  - That same sample already uses the new config.
  - Samples with in_wrap_i=0 never change the active config.
- Simultaneous commit and write to the same channel:
  - The old pending value commits.
  - The new write lands in pending and pend stays 1.
- Combine rules, applied over the selected waves only:
  - sel=0: output 0 (mute) in every mode.
  - AND: bitwise AND of the selected waves.
  - OR: bitwise OR of the selected waves.
  - MAX: largest selected value, compared unsigned.
  - XOR: see Optional Feature.
- Pipeline:
  - Stage 1 registers the waves, channel and resolved active config.
  - Stage 2 registers the combine result.
  - Latency: the first output is valid 2 cycles after the input transfer when there is no stall.
  - Throughput: 1 sample/cycle.
- Flow control:
  - s2 advances when !s2_vld | out_rdy_i.
  - s1 advances when !s1_vld | s2 advance.
  - in_rdy_o = !s1_vld | s1 advance. This path is combinational from out_rdy_i.
- Stall: while out_vld_o=1 and out_rdy_i=0, out_o and out_ch_o hold stable; no data is lost or duplicated.
- Reset mid-stream: in-flight samples are discarded; pending configs are lost.

Optional Feature:
- Macro: PSG_WAVE_COMBINER_XOR_EN.
- Defined: mode 2 gives the bitwise XOR of the selected waves.
- Undefined: mode 2 behaves exactly as AND, and the XOR tree is not synthesised.

Decomposition:
- Shared package psg_pkg holds:
  - mode constants PSG_CMB_AND=0, PSG_CMB_OR=1, PSG_CMB_XOR=2, PSG_CMB_MAX=3;
  - the config struct/width {sel[NWAVE], mode[2]}.
- One natural sub-module: psg_wave_combine_core.
  - Purely combinational: sel, mode, waves in; WID-bit result out.
  - Instantiated in stage 2.

Test Plan:
- Reset, then send ch0 waves a=0x0F0, b=0x0FF with no config -> out_o=0x000, out_ch_o=0, out_vld_o rises 2 cycles after accept.
- Write ch1 sel=00011 mode=AND; send ch1 with wrap=1, a=0xF0F, b=0x0FF -> out_o=0x00F, cfg_pend_o[1] clears after the accept.
- Write ch2 sel=00101 mode=MAX; send ch2 with wrap=0 -> old config used (out_o=0) and pend[2] stays 1; next wrap=1 sample with a=0x123, c=0x800 -> out_o=0x800.
- Mode 2 on ch3, sel=00011, a=0xAAA, b=0xFFF -> 0x555 with PSG_WAVE_COMBINER_XOR_EN defined, 0xAAA without.
- Hold out_rdy_i=0 for 5 cycles while streaming chs 0..3 -> in_rdy_o drops after 2 accepted; out_o stays stable; after release all 4 outputs arrive in order with no loss.
- Cfg write to ch4 in the same cycle as a wrap accept on ch4 with old pending pending -> old pending commits, new value stays pending, pend[4]=1.
